alu_sequencer: RTL and testbench

//  Parametrised operand-entry sequencer for the calculator datapath. Replaces the fixed
//  4/8/16-bit controller-plus-registers arrangement. Collects opcode, A and B from switches
//  on debounced 'enter' pulses and drives a multi-cycle ALU core over a start/done handshake.

---
 rtl/alu_sequencer_pkg.sv | 20 ++
 rtl/alu_sequencer_if.sv | 40 ++++
 rtl/alu_sequencer_history.sv | 66 ++++++
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the calculator operand-entry sequencer: state encoding and
// the pointer-width helper used by the result history.
package alu_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_e;

    // A one-entry history still needs a one-bit pointer to keep the declarations legal.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Switch/keypad inputs, ALU core handshake and display/debug outputs of the sequencer.
// The master modport is the sequencer's view; slave is the surrounding board/ALU view.
interface alu_sequencer_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    import alu_sequencer_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic               enter;
    logic               chain;
    logic               hist_prev;
    logic [3:0]         sw_op;
    logic [W-1:0]       sw_data;
    logic               alu_done;
    logic [2*W-1:0]     alu_result;
    logic [3:0]         opcode;
    logic [W-1:0]       opA;
    logic [W-1:0]       opB;
    logic               alu_start;
    logic [2*W-1:0]     result;
    logic [2*W-1:0]     disp_value;
    logic [STATE_W-1:0] state_code;
    logic               timeout_err;
    logic [CW-1:0]      hist_count;

    modport master (
        input  enter, chain, hist_prev, sw_op, sw_data, alu_done, alu_result,
        output opcode, opA, opB, alu_start, result, disp_value, state_code,
               timeout_err, hist_count
    );

    modport slave (
        output enter, chain, hist_prev, sw_op, sw_data, alu_done, alu_result,
        input  opcode, opA, opB, alu_start, result, disp_value, state_code,
               timeout_err, hist_count
    );

endinterface

// File: rtl/alu_sequencer_history.sv
// Ring buffer of accepted ALU results with a browse index counted back from the newest
// entry; the oldest entry is overwritten once the buffer is full.
module result_history_buffer
    import alu_sequencer_pkg::*;
#(
    parameter  int W2    = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W2-1:0] push_data,
    input  logic          step,
    input  logic          clear,
    output logic [W2-1:0] rd_data,
    output logic [CW-1:0] count
);

    logic [W2-1:0] mem_q [DEPTH];
    logic [W2-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] browse_q, browse_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        browse_d = browse_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end

        if (clear) begin
            browse_d = '0;
        end else if (step && (count_q != '0)) begin
            browse_d = (browse_q + 1'b1 == count_q) ? '0 : browse_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            count_q  <= '0;
            browse_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            browse_q <= browse_d;
        end
    end

    // Newest entry sits just behind the write pointer; browse walks further back from it.
    assign rd_data = mem_q[PW'((int'(wr_ptr_q) + DEPTH - 1 - int'(browse_q)) % DEPTH)];
    assign count   = count_q;

endmodule

// File: rtl/alu_sequencer.sv
// Operand-entry sequencer: collects opcode/A/B on enter pulses, runs the ALU core over a
// start/done handshake with a timeout, and records accepted results in a history buffer.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    alu_sequencer_if.master bus
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    state_e           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic             alu_start_q, alu_start_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             timeout_err_q, timeout_err_d;
    logic             res_valid_q, res_valid_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             hist_push, hist_step, hist_clear;
    logic [2*W-1:0]   hist_rd;
    logic [CW-1:0]    hist_count;

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        alu_start_d   = 1'b0;
        result_d      = result_q;
        timeout_err_d = timeout_err_q;
        res_valid_d   = res_valid_q;
        tcnt_d        = tcnt_q;
        hist_push     = 1'b0;
        hist_step     = 1'b0;
        hist_clear    = 1'b0;

        case (state_q)
            S_OP: begin
                if (bus.enter) begin
                    opcode_d = bus.sw_op;
                    // Chain mode reuses the low half of the last result as A and skips its entry.
                    if (bus.chain && res_valid_q) begin
                        op_a_d  = result_q[W-1:0];
                        state_d = S_B;
                    end else begin
                        state_d = S_A;
                    end
                end
            end
            S_A: begin
                if (bus.enter) begin
                    op_a_d  = bus.sw_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bus.enter) begin
                    op_b_d      = bus.sw_data;
                    alu_start_d = 1'b1;
                    tcnt_d      = '0;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                // A done in the last allowed cycle still wins over the timeout.
                if (bus.alu_done) begin
                    result_d    = bus.alu_result;
                    res_valid_d = 1'b1;
                    hist_push   = 1'b1;
                    state_d     = S_SHOW;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_SHOW;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_SHOW: begin
                if (bus.enter) begin
                    timeout_err_d = 1'b0;
                    hist_clear    = 1'b1;
                    state_d       = S_OP;
                end else if (bus.hist_prev) begin
                    hist_step = 1'b1;
                end
            end
            default: state_d = S_OP;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= S_OP;
            opcode_q      <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            alu_start_q   <= 1'b0;
            result_q      <= '0;
            timeout_err_q <= 1'b0;
            res_valid_q   <= 1'b0;
            tcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            alu_start_q   <= alu_start_d;
            result_q      <= result_d;
            timeout_err_q <= timeout_err_d;
            res_valid_q   <= res_valid_d;
            tcnt_q        <= tcnt_d;
        end
    end

    result_history_buffer #(
        .W2    (2 * W),
        .DEPTH (DEPTH)
    ) u_history (
        .clk       (CLOCK_50),
        .rst       (reset),
        .push      (hist_push),
        .push_data (bus.alu_result),
        .step      (hist_step),
        .clear     (hist_clear),
        .rd_data   (hist_rd),
        .count     (hist_count)
    );

    assign bus.opcode      = opcode_q;
    assign bus.opA         = op_a_q;
    assign bus.opB         = op_b_q;
    assign bus.alu_start   = alu_start_q;
    assign bus.result      = result_q;
    assign bus.state_code  = state_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.hist_count  = hist_count;
    assign bus.disp_value  = ((state_q == S_SHOW) && (hist_count != '0)) ? hist_rd : result_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised bench for alu_sequencer: the bench plays keypad and ALU core, and predicts
// results, history contents and display values from a queue-based model.
module tb_alu_sequencer;

    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;

    alu_sequencer_if #(.W(W), .DEPTH(DEPTH)) bus();

    alu_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_result;
    bit          m_valid;
    bit          m_terr;
    logic [15:0] m_hist[$];
    int          m_browse;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic model_reset();
        m_result = '0;
        m_valid  = 1'b0;
        m_terr   = 1'b0;
        m_hist.delete();
        m_browse = 0;
    endtask

    // Display prediction: newest-first history in S_SHOW, otherwise the last result.
    function automatic logic [15:0] m_disp(input bit in_show);
        if (in_show && (m_hist.size() > 0)) return m_hist[m_browse];
        return m_result;
    endfunction

    task automatic idle_inputs();
        bus.enter      = 1'b0;
        bus.chain      = 1'b0;
        bus.hist_prev  = 1'b0;
        bus.sw_op      = '0;
        bus.sw_data    = '0;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        model_reset();
    endtask

    task automatic enter_operands(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input bit ch);
        logic [7:0] exp_a;
        bus.sw_op   = op;
        bus.chain   = ch;
        bus.sw_data = 8'($urandom);
        bus.enter   = 1'b1;
        step();
        bus.enter = 1'b0;
        bus.chain = 1'($urandom_range(0, 1));
        checks++; if (bus.opcode !== op) begin failures++; $display("[TB] FAIL opcode_latch: got %0h expected %0h", bus.opcode, op); end
        if (ch && m_valid) begin
            exp_a = m_result[7:0];
            checks++; if (bus.state_code !== 3'd2) begin failures++; $display("[TB] FAIL chain_skip_state: got %0d expected 2", bus.state_code); end
        end else begin
            exp_a = a;
            checks++; if (bus.state_code !== 3'd1) begin failures++; $display("[TB] FAIL state_after_op: got %0d expected 1", bus.state_code); end
            bus.sw_data = a;
            bus.enter   = 1'b1;
            step();
            bus.enter = 1'b0;
            checks++; if (bus.state_code !== 3'd2) begin failures++; $display("[TB] FAIL state_after_a: got %0d expected 2", bus.state_code); end
        end
        checks++; if (bus.opA !== exp_a) begin failures++; $display("[TB] FAIL opA: got %0h expected %0h", bus.opA, exp_a); end
        bus.sw_data = b;
        bus.enter   = 1'b1;
        step();
        bus.enter = 1'b0;
        checks++; if (bus.state_code !== 3'd3) begin failures++; $display("[TB] FAIL state_after_b: got %0d expected 3", bus.state_code); end
        checks++; if (bus.opB !== b) begin failures++; $display("[TB] FAIL opB: got %0h expected %0h", bus.opB, b); end
    endtask

    // lat = S_EXEC cycle index (0 = start cycle) at which done is raised; >= TIMEOUT never.
    task automatic run_exec(input int lat, input logic [15:0] res, input bit noise);
        int n      = 0;
        int starts = 0;
        bit ok     = (lat >= 0) && (lat < TIMEOUT);
        int n_exp  = ok ? lat + 1 : TIMEOUT;
        starts += int'(bus.alu_start);
        while ((bus.state_code == 3'd3) && (n < 4 * TIMEOUT)) begin
            bus.alu_done   = ok && (n >= lat);
            bus.alu_result = (ok && (n >= lat)) ? res : 16'($urandom);
            if (noise) begin
                bus.enter     = 1'($urandom_range(0, 1));
                bus.hist_prev = 1'($urandom_range(0, 1));
            end
            step();
            n++;
            if (bus.state_code == 3'd3) starts += int'(bus.alu_start);
        end
        bus.enter     = 1'b0;
        bus.hist_prev = 1'b0;
        bus.alu_done  = 1'b0;
        if (ok) begin
            m_result = res;
            m_valid  = 1'b1;
            m_hist.push_front(res);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
        end else begin
            m_terr = 1'b1;
        end
        m_browse = 0;
        checks++; if (n !== n_exp) begin failures++; $display("[TB] FAIL exec_cycles: got %0d expected %0d", n, n_exp); end
        checks++; if (starts !== 1) begin failures++; $display("[TB] FAIL alu_start_pulses: got %0d expected 1", starts); end
        checks++; if (bus.state_code !== 3'd4) begin failures++; $display("[TB] FAIL state_show: got %0d expected 4", bus.state_code); end
        checks++; if (bus.result !== m_result) begin failures++; $display("[TB] FAIL result: got %0h expected %0h", bus.result, m_result); end
        checks++; if (bus.timeout_err !== m_terr) begin failures++; $display("[TB] FAIL timeout_err: got %0b expected %0b", bus.timeout_err, m_terr); end
        checks++; if (int'(bus.hist_count) !== m_hist.size()) begin failures++; $display("[TB] FAIL hist_count: got %0d expected %0d", bus.hist_count, m_hist.size()); end
        checks++; if (bus.disp_value !== m_disp(1'b1)) begin failures++; $display("[TB] FAIL disp_show: got %0h expected %0h", bus.disp_value, m_disp(1'b1)); end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit ch, input int lat, input logic [15:0] res, input bit noise);
        enter_operands(op, a, b, ch);
        run_exec(lat, res, noise);
    endtask

    task automatic show_browse(input int steps);
        for (int i = 0; i < steps; i++) begin
            bus.hist_prev = 1'b1;
            step();
            bus.hist_prev = 1'b0;
            if (m_hist.size() > 0) m_browse = (m_browse + 1) % m_hist.size();
            checks++; if (bus.state_code !== 3'd4) begin failures++; $display("[TB] FAIL browse_state: got %0d expected 4", bus.state_code); end
            checks++; if (bus.disp_value !== m_disp(1'b1)) begin failures++; $display("[TB] FAIL browse_disp: got %0h expected %0h", bus.disp_value, m_disp(1'b1)); end
        end
    endtask

    task automatic leave_show(input bit with_prev);
        bus.enter     = 1'b1;
        bus.hist_prev = with_prev;
        step();
        bus.enter     = 1'b0;
        bus.hist_prev = 1'b0;
        m_terr   = 1'b0;
        m_browse = 0;
        checks++; if (bus.state_code !== 3'd0) begin failures++; $display("[TB] FAIL leave_state: got %0d expected 0", bus.state_code); end
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL leave_terr: got %0b expected 0", bus.timeout_err); end
        checks++; if (bus.disp_value !== m_result) begin failures++; $display("[TB] FAIL leave_disp: got %0h expected %0h", bus.disp_value, m_result); end
    endtask

    task automatic check_all_zero(input string tag);
        checks++; if (bus.state_code !== 3'd0) begin failures++; $display("[TB] FAIL %s_state: got %0d expected 0", tag, bus.state_code); end
        checks++; if (bus.opcode !== 4'h0) begin failures++; $display("[TB] FAIL %s_opcode: got %0h expected 0", tag, bus.opcode); end
        checks++; if (bus.opA !== 8'h00) begin failures++; $display("[TB] FAIL %s_opA: got %0h expected 0", tag, bus.opA); end
        checks++; if (bus.opB !== 8'h00) begin failures++; $display("[TB] FAIL %s_opB: got %0h expected 0", tag, bus.opB); end
        checks++; if (bus.alu_start !== 1'b0) begin failures++; $display("[TB] FAIL %s_alu_start: got %0b expected 0", tag, bus.alu_start); end
        checks++; if (bus.result !== 16'h0) begin failures++; $display("[TB] FAIL %s_result: got %0h expected 0", tag, bus.result); end
        checks++; if (bus.disp_value !== 16'h0) begin failures++; $display("[TB] FAIL %s_disp: got %0h expected 0", tag, bus.disp_value); end
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL %s_terr: got %0b expected 0", tag, bus.timeout_err); end
        checks++; if (bus.hist_count !== 3'd0) begin failures++; $display("[TB] FAIL %s_hist_count: got %0d expected 0", tag, bus.hist_count); end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        model_reset();
        check_all_zero("post_reset");
    endtask

    task automatic test_basic();
        do_op(4'd3, 8'h12, 8'h34, 1'b0, 5, 16'h0046, 1'b0);
        checks++; if (bus.result !== 16'h0046) begin failures++; $display("[TB] FAIL basic_result: got %0h expected 0046", bus.result); end
        checks++; if (bus.hist_count !== 3'd1) begin failures++; $display("[TB] FAIL basic_hist_count: got %0d expected 1", bus.hist_count); end
        leave_show(1'b0);
    endtask

    task automatic test_chain();
        do_op(4'($urandom), 8'($urandom), 8'($urandom), 1'b0, 2, 16'h01A5, 1'b0);
        leave_show(1'b0);
        enter_operands(4'd7, 8'h00, 8'h02, 1'b1);
        checks++; if (bus.opA !== 8'hA5) begin failures++; $display("[TB] FAIL chain_opA: got %0h expected a5", bus.opA); end
        run_exec(3, 16'($urandom), 1'b0);
        leave_show(1'b0);
    endtask

    task automatic test_timeout();
        apply_reset();
        do_op(4'd1, 8'h10, 8'h20, 1'b0, TIMEOUT + 10, 16'hDEAD, 1'b0);
        show_browse(1);
        leave_show(1'b0);
        do_op(4'd2, 8'h11, 8'h22, 1'b0, TIMEOUT - 1, 16'h1234, 1'b0);
        leave_show(1'b0);
        do_op(4'd5, 8'h33, 8'h44, 1'b1, TIMEOUT, 16'hBEEF, 1'b0);
        checks++; if (bus.result !== 16'h1234) begin failures++; $display("[TB] FAIL timeout_result_kept: got %0h expected 1234", bus.result); end
        leave_show(1'b0);
    endtask

    task automatic test_history_wrap();
        apply_reset();
        for (int i = 1; i <= 6; i++) begin
            do_op(4'($urandom), 8'($urandom), 8'($urandom), 1'b0, $urandom_range(0, 3), 16'(i), 1'b1);
            if (i < 6) leave_show(1'b0);
        end
        checks++; if (bus.disp_value !== 16'd6) begin failures++; $display("[TB] FAIL wrap_newest: got %0h expected 6", bus.disp_value); end
        show_browse(4);
        checks++; if (bus.disp_value !== 16'd6) begin failures++; $display("[TB] FAIL wrap_browse_cycle: got %0h expected 6", bus.disp_value); end
    endtask

    task automatic test_back_to_back();
        show_browse(1);
        leave_show(1'b1);
        do_op(4'($urandom), 8'($urandom), 8'($urandom), 1'b0, $urandom_range(0, 4), 16'($urandom), 1'b1);
        leave_show(1'b0);
    endtask

    task automatic test_reset_mid_exec();
        enter_operands(4'd9, 8'h5A, 8'hA5, 1'b0);
        step();
        bus.alu_done   = 1'b1;
        bus.alu_result = 16'hBEEF;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        step();
        #2;
        reset = 1'b0;
        step();
        bus.alu_done = 1'b0;
        model_reset();
        check_all_zero("after_mid_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            do_op(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 6),
                  16'($urandom), 1'b1);
            show_browse($urandom_range(0, 5));
            leave_show(1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_basic();
        test_chain();
        test_timeout();
        test_history_wrap();
        test_back_to_back();
        test_reset_mid_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
